// File: rtl/conv_tile_sequencer_if.sv
// Valid/ready word stream used on both sides of the tile sequencer.
//   valid : word present (master -> slave)
//   ready : slave can take the word (slave -> master)
//   data  : DATA_W-bit payload
//   last  : marks the final word of a burst
interface conv_tile_sequencer_if #(
  parameter int DATA_W = 16
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              last;

  modport master(output valid, output data, output last, input ready);
  modport slave (input valid, input data, input last, output ready);
endinterface

// File: rtl/conv_tile_sequencer.sv
// Stream front/back end for the 3x3 PE array tile.
// Packs 9 filter words then 25 ifmap words from the input stream into flat
// buses, pulses arr_load, holds arr_en for the compute window, snapshots the
// 9-word result bus and drains it on the output stream.
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   flush         : synchronous abort back to filter loading
//   s (slave)     : input word stream (s.last is not used)
//   m (master)    : result word stream, m.last on result word 8
//   filter_flat   : 9 packed filter words, word k at [k*DATA_W +: DATA_W]
//   ifmap_flat    : 25 packed ifmap words
//   arr_load/en   : array load and enable controls
//   sum_flat      : array result bus (9 words)
//   busy          : high while loading the array, running or draining
module conv_tile_sequencer #(
  parameter int DATA_W      = 16,
  parameter int LOAD_CYCLES = 2,
  parameter int RUN_CYCLES  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  conv_tile_sequencer_if.slave    s,
  conv_tile_sequencer_if.master   m,
  output logic [9*DATA_W-1:0]     filter_flat,
  output logic [25*DATA_W-1:0]    ifmap_flat,
  output logic                    arr_load,
  output logic                    arr_en,
  input  logic [9*DATA_W-1:0]     sum_flat,
  output logic                    busy
);
  localparam int MAXC = (LOAD_CYCLES > RUN_CYCLES) ? LOAD_CYCLES : RUN_CYCLES;
  localparam int PH_W = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [PH_W-1:0] PH_LD_END  = PH_W'(LOAD_CYCLES - 1);
  localparam logic [PH_W-1:0] PH_RUN_END = PH_W'(RUN_CYCLES - 1);

  typedef enum logic [2:0] {LOAD_F, LOAD_I, ARR_LOAD, RUN, DRAIN} state_t;

  state_t                     state, state_nx;
  logic [3:0]                 f_cnt;
  logic [4:0]                 i_cnt;
  logic [PH_W-1:0]            ph;
  logic [3:0]                 idx;
  logic                       out_en;
  logic [8:0][DATA_W-1:0]     filt_q, snap_q;
  logic [24:0][DATA_W-1:0]    ifm_q;
  logic                       acc_in, acc_out, ld_end, run_end;

  // flush wins over any handshake in the same cycle
  assign acc_in  = s.valid && s.ready && !flush;
  assign acc_out = m.valid && m.ready && !flush;
  assign ld_end  = (state == ARR_LOAD) && (ph == PH_LD_END);
  assign run_end = (state == RUN) && (ph == PH_RUN_END);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= LOAD_F;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    if (flush) state_nx = LOAD_F;
    else begin
      case (state)
        LOAD_F:   if (acc_in && f_cnt == 4'd8)  state_nx = LOAD_I;
        LOAD_I:   if (acc_in && i_cnt == 5'd24) state_nx = ARR_LOAD;
        ARR_LOAD: if (ld_end)                   state_nx = RUN;
        RUN:      if (run_end)                  state_nx = DRAIN;
        DRAIN:    if (acc_out && idx == 4'd8)   state_nx = LOAD_F;
        default:                                state_nx = LOAD_F;
      endcase
    end
  end

  // counters: each wraps to 0 exactly when its state is left
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_cnt <= '0; i_cnt <= '0; ph <= '0; idx <= '0;
    end else if (flush) begin
      f_cnt <= '0; i_cnt <= '0; ph <= '0; idx <= '0;
    end else begin
      case (state)
        LOAD_F:   if (acc_in)  f_cnt <= (f_cnt == 4'd8)  ? 4'd0 : f_cnt + 4'd1;
        LOAD_I:   if (acc_in)  i_cnt <= (i_cnt == 5'd24) ? 5'd0 : i_cnt + 5'd1;
        ARR_LOAD:              ph    <= ld_end  ? '0 : ph + 1'b1;
        RUN:                   ph    <= run_end ? '0 : ph + 1'b1;
        DRAIN:    if (acc_out) idx   <= (idx == 4'd8)    ? 4'd0 : idx + 4'd1;
        default: ;
      endcase
    end
  end

  // word stores; flush leaves previously loaded words in place
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= '0;
      ifm_q  <= '0;
      snap_q <= '0;
    end else begin
      if (acc_in && state == LOAD_F) filt_q[f_cnt] <= s.data;
      if (acc_in && state == LOAD_I) ifm_q[i_cnt]  <= s.data;
      if (run_end && !flush)         snap_q        <= sum_flat;
    end
  end

  // keeps s.ready low while reset is held, high from the first edge after
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) out_en <= 1'b0;
    else        out_en <= 1'b1;

  assign s.ready     = out_en && (state == LOAD_F || state == LOAD_I);
  assign arr_load    = (state == ARR_LOAD);
  assign arr_en      = (state == RUN);
  assign busy        = (state == ARR_LOAD) || (state == RUN) || (state == DRAIN);
  assign m.valid     = (state == DRAIN);
  assign m.data      = (state == DRAIN) ? snap_q[idx] : '0;
  assign m.last      = (state == DRAIN) && (idx == 4'd8);
  assign filter_flat = filt_q;
  assign ifmap_flat  = ifm_q;
endmodule

// File: tb/tb_conv_tile_sequencer.sv
module tb_conv_tile_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic [9*16-1:0]  filter_flat, sum_flat;
  logic [25*16-1:0] ifmap_flat;
  logic arr_load, arr_en, busy;
  int checks = 0, failures = 0;

  conv_tile_sequencer_if #(.DATA_W(16)) s_if();
  conv_tile_sequencer_if #(.DATA_W(16)) m_if();

  conv_tile_sequencer dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .s(s_if.slave), .m(m_if.master),
    .filter_flat(filter_flat), .ifmap_flat(ifmap_flat),
    .arr_load(arr_load), .arr_en(arr_en),
    .sum_flat(sum_flat), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic [15:0] data;
    logic        last;
  } dvec_t;
  dvec_t dtab[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // hold one word until accepted, with a cycle budget
  task automatic send_word(input logic [15:0] d);
    logic r;
    int n;
    s_if.valid = 1'b1; s_if.data = d;
    r = 1'b0; n = 0;
    while (!r && n < 50) begin
      @(negedge clk); r = s_if.ready;
      tick(); n++;
    end
    if (!r) chk("send_timeout", 0, 1);
    s_if.valid = 1'b0;
  endtask

  task automatic load_tile(input logic [15:0] fb, input logic [15:0] ib, input bit gaps);
    for (int i = 0; i < 34; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      send_word((i < 9) ? fb + 16'(i) : ib + 16'(i - 9));
    end
  endtask

  task automatic set_sum(input logic [15:0] b);
    for (int i = 0; i < 9; i++) sum_flat[i*16 +: 16] = b + 16'(i);
  endtask

  // cycles E+1..E+11 after the last ifmap word; ends inside cycle E+11
  task automatic ctrl_phase(input bit junk, input bit isolate);
    int nl = 0, ne = 0;
    if (junk) begin s_if.valid = 1'b1; s_if.data = 16'h0BAD; end
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      nl += arr_load; ne += arr_en;
      chk("arr_load_k", arr_load, (k <= 2));
      chk("arr_en_k",   arr_en,   (k >= 3 && k <= 10));
      chk("m_valid_k",  m_if.valid, (k == 11));
      chk("s_ready_busy", s_if.ready, 0);
      if (k < 11) tick();
    end
    chk("arr_load_cycles", nl, 2);
    chk("arr_en_cycles",   ne, 8);
    s_if.valid = 1'b0;
    if (isolate) sum_flat = {9{16'hFFFF}};
  endtask

  task automatic drain_plain(input logic [15:0] b);
    for (int i = 0; i < 9; i++) begin
      m_if.ready = 1'b1; #1;
      chk("drain_valid", m_if.valid, 1);
      chk("drain_data",  m_if.data, b + 16'(i));
      chk("drain_last",  m_if.last, (i == 8));
      tick();
    end
    m_if.ready = 1'b0;
    chk("post_drain_s_ready", s_if.ready, 1);
    chk("post_drain_m_valid", m_if.valid, 0);
  endtask

  initial begin
    dtab[0]  = '{1'b1, 16'h10, 1'b0};
    dtab[1]  = '{1'b1, 16'h11, 1'b0};
    dtab[2]  = '{1'b1, 16'h12, 1'b0};
    dtab[3]  = '{1'b0, 16'h13, 1'b0};
    dtab[4]  = '{1'b0, 16'h13, 1'b0};
    dtab[5]  = '{1'b0, 16'h13, 1'b0};
    dtab[6]  = '{1'b0, 16'h13, 1'b0};
    dtab[7]  = '{1'b0, 16'h13, 1'b0};
    dtab[8]  = '{1'b1, 16'h13, 1'b0};
    dtab[9]  = '{1'b1, 16'h14, 1'b0};
    dtab[10] = '{1'b1, 16'h15, 1'b0};
    dtab[11] = '{1'b1, 16'h16, 1'b0};
    dtab[12] = '{1'b1, 16'h17, 1'b0};
    dtab[13] = '{1'b1, 16'h18, 1'b1};

    s_if.valid = 1'b0; s_if.data = '0; s_if.last = 1'b0;
    m_if.ready = 1'b0; sum_flat = '0;

    // reset state
    #12;
    chk("rst_s_ready", s_if.ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m_data", m_if.data, 0);
    chk("rst_filter", filter_flat[31:0], 0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("rel_s_ready", s_if.ready, 1);
    chk("rel_arr_load", arr_load, 0);

    // tile A: no gaps, plain drain
    set_sum(16'h10);
    load_tile(16'd1, 16'd100, 1'b0);
    chk("filt0", filter_flat[0 +: 16], 1);
    chk("filt8", filter_flat[8*16 +: 16], 9);
    chk("ifm0",  ifmap_flat[0 +: 16], 100);
    chk("ifm24", ifmap_flat[24*16 +: 16], 124);
    ctrl_phase(1'b0, 1'b0);
    drain_plain(16'h10);

    // tile B: input gaps, junk during run, snapshot isolation, backpressure
    set_sum(16'h10);
    load_tile(16'd11, 16'd300, 1'b1);
    for (int i = 0; i < 9; i++)  chk("filtB", filter_flat[i*16 +: 16], 11 + i);
    for (int i = 0; i < 25; i++) chk("ifmB",  ifmap_flat[i*16 +: 16], 300 + i);
    ctrl_phase(1'b1, 1'b1);
    for (int i = 0; i < 14; i++) begin
      m_if.ready = dtab[i].rdy; #1;
      chk("bp_valid", m_if.valid, 1);
      chk("bp_data",  m_if.data, dtab[i].data);
      chk("bp_last",  m_if.last, dtab[i].last);
      tick();
    end
    m_if.ready = 1'b0;
    chk("bp_s_ready", s_if.ready, 1);
    chk("junk_ignored", ifmap_flat[0 +: 16], 300);

    // flush after 20 words, coincident with a valid word
    for (int i = 0; i < 20; i++) send_word((i < 9) ? 16'd50 + 16'(i) : 16'd200 + 16'(i - 9));
    s_if.valid = 1'b1; s_if.data = 16'hDEAD; flush = 1'b1;
    tick();
    flush = 1'b0; s_if.valid = 1'b0;
    chk("fl_busy", busy, 0);
    chk("fl_s_ready", s_if.ready, 1);
    chk("fl_ifm10", ifmap_flat[10*16 +: 16], 210);
    chk("fl_ifm11", ifmap_flat[11*16 +: 16], 311);
    chk("fl_filt0", filter_flat[0 +: 16], 50);
    set_sum(16'h20);
    load_tile(16'd1, 16'd100, 1'b0);
    chk("fl2_filt0", filter_flat[0 +: 16], 1);
    chk("fl2_ifm0",  ifmap_flat[0 +: 16], 100);
    chk("fl2_ifm11", ifmap_flat[11*16 +: 16], 111);
    chk("fl2_ifm24", ifmap_flat[24*16 +: 16], 124);
    ctrl_phase(1'b0, 1'b0);
    drain_plain(16'h20);

    // asynchronous reset in the middle of RUN
    load_tile(16'd1, 16'd100, 1'b0);
    repeat (4) tick();
    chk("mid_run_en", arr_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_arr_en", arr_en, 0);
    chk("ar_arr_load", arr_load, 0);
    chk("ar_busy", busy, 0);
    chk("ar_s_ready", s_if.ready, 0);
    chk("ar_m_valid", m_if.valid, 0);
    chk("ar_m_last", m_if.last, 0);
    chk("ar_filter", filter_flat[0 +: 16], 0);
    chk("ar_ifmap", ifmap_flat[24*16 +: 16], 0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("ar_rel_s_ready", s_if.ready, 1);
    chk("ar_rel_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
